// File: rtl/duck_motion_ctl.sv
// Duck motion controller: spawns a duck, moves it across the screen once per
// frame, handles a shot duck falling to the ground, and reports escape/landing.
module duck_motion_ctl #(
  parameter int unsigned X_MAX      = 960,
  parameter int unsigned Y_START    = 600,
  parameter int unsigned H_SPEED    = 4,
  parameter int unsigned FALL_SPEED = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       hit,
  input  logic       rnd_direction,
  input  logic [9:0] rnd_start_pos,
  input  logic [4:0] rnd_vspeed,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic       duck_dir,
  output logic       duck_visible,
  output logic       busy,
  output logic       escaped,
  output logic       fallen
);

  typedef enum logic [1:0] {IDLE, FLY, FALL} state_t;

  state_t     state;
  logic [4:0] vspeed;

  logic [10:0] x_ext, y_ext, vs_ext;
  logic [10:0] x_right, y_fall;
  logic        right_over, left_under, y_escape, y_land;
  logic [9:0]  spawn_x;
  logic [4:0]  spawn_vs;

  // Widened arithmetic and boundary decisions for the current position.
  always_comb begin
    x_ext      = {1'b0, duck_x};
    y_ext      = {1'b0, duck_y};
    vs_ext     = {6'b0, vspeed};
    x_right    = x_ext + 11'(H_SPEED);
    y_fall     = y_ext + 11'(FALL_SPEED);
    right_over = x_right > 11'(X_MAX);
    left_under = x_ext < 11'(H_SPEED);
    y_escape   = y_ext < vs_ext;
    y_land     = y_fall >= 11'(Y_START);
    spawn_x    = ({1'b0, rnd_start_pos} > 11'(X_MAX)) ? 10'(X_MAX) : rnd_start_pos;
    spawn_vs   = (rnd_vspeed == '0) ? 5'd1 : rnd_vspeed;
  end

  // State machine with all outputs registered; hit outranks frame_tick in FLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      duck_x       <= '0;
      duck_y       <= '0;
      duck_dir     <= 1'b0;
      duck_visible <= 1'b0;
      busy         <= 1'b0;
      escaped      <= 1'b0;
      fallen       <= 1'b0;
      vspeed       <= '0;
    end else begin
      escaped <= 1'b0;
      fallen  <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn) begin
            state        <= FLY;
            duck_x       <= spawn_x;
            duck_y       <= 10'(Y_START);
            duck_dir     <= rnd_direction;
            vspeed       <= spawn_vs;
            duck_visible <= 1'b1;
            busy         <= 1'b1;
          end
        end
        FLY: begin
          if (hit) begin
            state <= FALL;
          end else if (frame_tick) begin
            if (duck_dir) begin
              if (right_over) begin
                duck_x   <= 10'(X_MAX);
                duck_dir <= 1'b0;
              end else begin
                duck_x <= x_right[9:0];
              end
            end else begin
              if (left_under) begin
                duck_x   <= '0;
                duck_dir <= 1'b1;
              end else begin
                duck_x <= duck_x - 10'(H_SPEED);
              end
            end
            if (y_escape) begin
              duck_y       <= '0;
              escaped      <= 1'b1;
              state        <= IDLE;
              duck_visible <= 1'b0;
              busy         <= 1'b0;
            end else begin
              duck_y <= duck_y - {5'b0, vspeed};
            end
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (y_land) begin
              duck_y       <= 10'(Y_START);
              fallen       <= 1'b1;
              state        <= IDLE;
              duck_visible <= 1'b0;
              busy         <= 1'b0;
            end else begin
              duck_y <= y_fall[9:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Directed bench for duck_motion_ctl: reset, edge clamps, hit/fall, escape,
// and ignored inputs.
module tb_duck_motion_ctl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, spawn, hit, rnd_direction;
  logic [9:0] rnd_start_pos;
  logic [4:0] rnd_vspeed;
  logic [9:0] duck_x, duck_y;
  logic       duck_dir, duck_visible, busy, escaped, fallen;

  int tests = 0;
  int fails = 0;

  duck_motion_ctl #(.X_MAX(960), .Y_START(600), .H_SPEED(4), .FALL_SPEED(8)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn(spawn), .hit(hit),
    .rnd_direction(rnd_direction), .rnd_start_pos(rnd_start_pos), .rnd_vspeed(rnd_vspeed),
    .duck_x(duck_x), .duck_y(duck_y), .duck_dir(duck_dir), .duck_visible(duck_visible),
    .busy(busy), .escaped(escaped), .fallen(fallen)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle; inputs are pulses cleared afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0; spawn = 1'b0; hit = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic do_spawn(input logic [9:0] pos, input logic dir, input logic [4:0] vs);
    rnd_start_pos = pos; rnd_direction = dir; rnd_vspeed = vs; spawn = 1'b1;
    step();
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; spawn = 1'b1; frame_tick = 1'b1;
    rnd_start_pos = 10'd100; rnd_direction = 1'b1; rnd_vspeed = 5'd3;
    @(posedge clk); #1;
    tests++;
    if ({duck_x, duck_y, duck_dir, duck_visible, busy, escaped, fallen} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs: x=%0d y=%0d dir=%b vis=%b busy=%b esc=%b fal=%b, required all 0",
               duck_x, duck_y, duck_dir, duck_visible, busy, escaped, fallen);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_held: busy=%b, required 0", busy);
    end
    rst = 1'b0; spawn = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic test_right_clamp();
    do_reset();
    do_spawn(10'd1000, 1'b1, 5'd0);
    tests++;
    if ({duck_x, duck_y, duck_dir, duck_visible, busy} !== {10'd960, 10'd600, 1'b1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL right_spawn: x=%0d y=%0d dir=%b vis=%b busy=%b, required 960 600 1 1 1",
               duck_x, duck_y, duck_dir, duck_visible, busy);
    end
    do_tick();
    tests++;
    if ({duck_x, duck_y, duck_dir} !== {10'd960, 10'd599, 1'b0}) begin
      fails++;
      $display("FAIL right_clamp_tick: x=%0d y=%0d dir=%b, required 960 599 0", duck_x, duck_y, duck_dir);
    end
  endtask

  task automatic test_left_clamp();
    do_reset();
    do_spawn(10'd2, 1'b0, 5'd10);
    do_tick();
    tests++;
    if ({duck_x, duck_y, duck_dir} !== {10'd0, 10'd590, 1'b1}) begin
      fails++;
      $display("FAIL left_clamp_tick1: x=%0d y=%0d dir=%b, required 0 590 1", duck_x, duck_y, duck_dir);
    end
    do_tick();
    tests++;
    if ({duck_x, duck_y, duck_dir} !== {10'd4, 10'd580, 1'b1}) begin
      fails++;
      $display("FAIL left_clamp_tick2: x=%0d y=%0d dir=%b, required 4 580 1", duck_x, duck_y, duck_dir);
    end
  endtask

  task automatic test_hit_tick();
    do_reset();
    do_spawn(10'd2, 1'b0, 5'd10);
    do_tick();                       // x=0 y=590 dir=1
    hit = 1'b1; frame_tick = 1'b1;
    step();
    tests++;
    if ({duck_x, duck_y, duck_dir, duck_visible, busy} !== {10'd0, 10'd590, 1'b1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL hit_tick_frozen: x=%0d y=%0d dir=%b vis=%b busy=%b, required 0 590 1 1 1",
               duck_x, duck_y, duck_dir, duck_visible, busy);
    end
    do_tick();
    tests++;
    if ({duck_x, duck_y, fallen} !== {10'd0, 10'd598, 1'b0}) begin
      fails++;
      $display("FAIL fall_tick1: x=%0d y=%0d fallen=%b, required 0 598 0", duck_x, duck_y, fallen);
    end
    do_tick();
    tests++;
    if ({duck_y, fallen, escaped, duck_visible, busy} !== {10'd600, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL fall_land: y=%0d fallen=%b esc=%b vis=%b busy=%b, required 600 1 0 0 0",
               duck_y, fallen, escaped, duck_visible, busy);
    end
    do_tick();
    tests++;
    if ({fallen, busy, duck_y} !== {1'b0, 1'b0, 10'd600}) begin
      fails++;
      $display("FAIL fall_pulse_once: fallen=%b busy=%b y=%0d, required 0 0 600", fallen, busy, duck_y);
    end
  endtask

  task automatic test_escape();
    do_reset();
    do_spawn(10'd100, 1'b1, 5'd31);
    for (int i = 0; i < 19; i++) begin
      do_tick();
      step();                        // idle cycle between frames
    end
    tests++;
    if ({duck_y, escaped, busy} !== {10'd11, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL escape_19: y=%0d esc=%b busy=%b, required 11 0 1", duck_y, escaped, busy);
    end
    do_tick();
    tests++;
    if ({duck_y, escaped, fallen, duck_visible, busy} !== {10'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL escape_20: y=%0d esc=%b fal=%b vis=%b busy=%b, required 0 1 0 0 0",
               duck_y, escaped, fallen, duck_visible, busy);
    end
    do_tick();
    tests++;
    if ({escaped, busy, duck_y} !== {1'b0, 1'b0, 10'd0}) begin
      fails++;
      $display("FAIL escape_pulse_once: esc=%b busy=%b y=%0d, required 0 0 0", escaped, busy, duck_y);
    end
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    do_spawn(10'd200, 1'b1, 5'd5);
    do_spawn(10'd50, 1'b0, 5'd20);   // must be ignored in FLY
    tests++;
    if ({duck_x, duck_y, duck_dir} !== {10'd200, 10'd600, 1'b1}) begin
      fails++;
      $display("FAIL spawn_in_fly: x=%0d y=%0d dir=%b, required 200 600 1", duck_x, duck_y, duck_dir);
    end
    do_tick();
    tests++;
    if ({duck_x, duck_y, duck_dir} !== {10'd204, 10'd595, 1'b1}) begin
      fails++;
      $display("FAIL no_resample: x=%0d y=%0d dir=%b, required 204 595 1", duck_x, duck_y, duck_dir);
    end
    do_reset();
    hit = 1'b1;
    step();
    tests++;
    if ({busy, duck_visible, duck_x, duck_y} !== {1'b0, 1'b0, 10'd0, 10'd0}) begin
      fails++;
      $display("FAIL hit_in_idle: busy=%b vis=%b x=%0d y=%0d, required 0 0 0 0", busy, duck_visible, duck_x, duck_y);
    end
    do_spawn(10'd300, 1'b0, 5'd3);
    do_tick();                       // x=296 y=597
    hit = 1'b1;
    step();                          // FALL
    do_tick();                       // y=605 -> lands? 597+8=605 >= 600
    tests++;
    if ({duck_y, fallen, busy} !== {10'd600, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL fall_clamp_short: y=%0d fallen=%b busy=%b, required 600 1 0", duck_y, fallen, busy);
    end
    do_spawn(10'd300, 1'b0, 5'd20);
    do_tick();                       // y=580
    hit = 1'b1;
    step();                          // FALL at y=580
    do_tick();                       // y=588, still falling
    rst = 1'b1; frame_tick = 1'b1;
    step();
    tests++;
    if ({duck_x, duck_y, duck_dir, duck_visible, busy, escaped, fallen} !== 25'd0) begin
      fails++;
      $display("FAIL reset_mid_fall: x=%0d y=%0d dir=%b vis=%b busy=%b esc=%b fal=%b, required all 0",
               duck_x, duck_y, duck_dir, duck_visible, busy, escaped, fallen);
    end
    do_tick();
    tests++;
    if ({busy, duck_y, fallen} !== {1'b0, 10'd0, 1'b0}) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b y=%0d fallen=%b, required 0 0 0", busy, duck_y, fallen);
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; spawn = 1'b0; hit = 1'b0;
    rnd_direction = 1'b0; rnd_start_pos = '0; rnd_vspeed = '0;
    #2;
    test_reset();
    test_right_clamp();
    test_left_clamp();
    test_hit_tick();
    test_escape();
    test_ignored_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/duck_motion_ctl.md
DUCK_MOTION_CTL -- requirements
Module: duck_motion_ctl

Interface
REQ-001 Parameter X_MAX, 960, rightmost legal duck_x.
REQ-002 Parameter Y_START, 600, spawn row and ground row for duck_y.
REQ-003 Parameter H_SPEED, 4, horizontal pixels moved per frame in FLY.
REQ-004 Parameter FALL_SPEED, 8, vertical pixels moved per frame in FALL.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 frame_tick  in  1  single-cycle pulse, one per video frame.
REQ-008 spawn  in  1  single-cycle request to launch a duck.
REQ-009 hit  in  1  single-cycle pulse meaning the duck was shot.
REQ-010 rnd_direction  in  1  random initial direction; 1 = right, 0 = left.
REQ-011 rnd_start_pos  in  10  random start column.
REQ-012 rnd_vspeed  in  5  random upward speed, in pixels per frame.
REQ-013 duck_x  out  10  current column.
REQ-014 duck_y  out  10  current row; 0 = top of screen.
REQ-015 duck_dir  out  1  current horizontal direction.
REQ-016 duck_visible  out  1  high while the duck is in FLY or FALL.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 escaped  out  1  single-cycle pulse when the duck leaves the top of the screen.
REQ-019 fallen  out  1  single-cycle pulse when a shot duck reaches the ground.

Function
REQ-020 The block SHALL implement three states, IDLE, FLY and FALL, with every output registered.
REQ-021 In IDLE, a spawn pulse SHALL sample all rnd_* inputs in that cycle, and the block SHALL enter FLY with the new values visible on the next cycle.
REQ-022 Spawn values SHALL be: duck_x = min(rnd_start_pos, X_MAX); duck_y = Y_START; duck_dir = rnd_direction; internal vspeed = max(rnd_vspeed, 1).
REQ-023 A spawn pulse outside IDLE SHALL be ignored, and the rnd_* inputs SHALL NOT be sampled.
REQ-024 In FLY, each frame_tick SHALL move duck_x by +H_SPEED when duck_dir = 1 and by -H_SPEED when duck_dir = 0.
REQ-025 If duck_x + H_SPEED > X_MAX, duck_x SHALL clamp to X_MAX and duck_dir SHALL flip to 0 in the same update.
REQ-026 If duck_x < H_SPEED while moving left, duck_x SHALL clamp to 0 and duck_dir SHALL flip to 1 in the same update.
REQ-027 In FLY, each frame_tick SHALL decrement duck_y by vspeed when duck_y >= vspeed.
REQ-028 In FLY, on a frame_tick with duck_y < vspeed, the block SHALL set duck_y = 0, pulse escaped for one cycle, and go to IDLE.
REQ-029 On entering IDLE from FLY, duck_visible SHALL fall in that same registered update, and duck_x SHALL hold its last value.
REQ-030 In FLY, a hit pulse SHALL move the block to FALL on the next cycle, with duck_x, duck_y and duck_dir frozen.
REQ-031 When hit and frame_tick arrive in the same cycle, hit SHALL take priority, and no movement SHALL occur in that cycle.
REQ-032 A hit pulse outside FLY SHALL be ignored.
REQ-033 In FALL, each frame_tick SHALL increment duck_y by FALL_SPEED, with duck_x unchanged.
REQ-034 In FALL, if duck_y + FALL_SPEED >= Y_START, duck_y SHALL clamp to Y_START, fallen SHALL pulse for one cycle, and the block SHALL go to IDLE.
REQ-035 The escaped and fallen pulses SHALL never both be high in the same cycle.
REQ-036 All arithmetic SHALL use at least 11-bit intermediates so that no comparison wraps.

Reset
REQ-037 While rst is high, the state SHALL be IDLE, and duck_x, duck_y, duck_dir, duck_visible, busy, escaped, fallen and the internal vspeed SHALL all be 0.
REQ-038 rst SHALL take priority over spawn, hit and frame_tick in every state, including mid-FLY and mid-FALL.

Verification
REQ-039 Reset case: assert rst with spawn=1 -> all outputs 0 on the next cycle, and busy stays 0.
REQ-040 Right-edge clamp: spawn with rnd_start_pos=1000, rnd_direction=1, rnd_vspeed=0 -> x=960, y=600, dir=1, visible=1; after the first tick -> x=960, dir=0, y=599.
REQ-041 Left-edge clamp: spawn with rnd_start_pos=2, rnd_direction=0, rnd_vspeed=10 -> after the first tick x=0, dir=1, y=590; after the second tick x=4, y=580.
REQ-042 Hit and tick together: with y=590, assert hit and frame_tick in the same cycle -> no move and state FALL; tick -> y=598; tick -> y=600, fallen pulses once, visible=0, busy=0.
REQ-043 Escape: spawn with rnd_vspeed=31 -> after 19 ticks y=11; on the 20th tick y=0, escaped pulses once, state IDLE.
REQ-044 Ignored and mid-operation inputs: spawn during FLY -> position unchanged and no resample; hit in IDLE -> no effect; rst mid-FALL -> IDLE with all outputs 0 on the next cycle.
